gshare_branch_predictor_ctrl: RTL and testbench

//  Gshare direction predictor controller for the 5-stage pipeline. It owns the global

---
 rtl/gshare_branch_predictor_ctrl_if.sv | 30 +++
 rtl/gshare_branch_predictor_ctrl.sv | 128 ++++++++++++
 tb/tb_gshare_branch_predictor_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_ctrl_if.sv
// rtl/gshare_branch_predictor_ctrl_if.sv - lookup/resolve signal bundle between pipeline and gshare predictor
interface gshare_branch_predictor_ctrl_if #(
  parameter int GHR_BITS = 4
);
  logic                ready;
  logic                lk_valid;
  logic [31:0]         lk_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                rs_valid;
  logic [31:0]         rs_pc;
  logic [GHR_BITS-1:0] rs_ghr;
  logic                rs_pred;
  logic                rs_taken;
  logic                mispredict;
  logic [GHR_BITS-1:0] arch_ghr;

  // Pipeline side: issues lookups from IF and resolves from ID_EX.
  modport master (
    input  ready, pred_valid, pred_taken, pred_ghr, mispredict, arch_ghr,
    output lk_valid, lk_pc, rs_valid, rs_pc, rs_ghr, rs_pred, rs_taken
  );

  // Predictor side.
  modport slave (
    output ready, pred_valid, pred_taken, pred_ghr, mispredict, arch_ghr,
    input  lk_valid, lk_pc, rs_valid, rs_pc, rs_ghr, rs_pred, rs_taken
  );
endinterface

// File: rtl/gshare_branch_predictor_ctrl.sv
// rtl/gshare_branch_predictor_ctrl.sv - gshare direction predictor with speculative/committed history and PHT init sweep
module gshare_branch_predictor_ctrl #(
  parameter int GHR_BITS = 4,
  parameter int IDX_BITS = 4,
  parameter int PC_LSB   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  gshare_branch_predictor_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0] arch_ghr_q, arch_ghr_d;
  logic [GHR_BITS-1:0] pred_ghr_q, pred_ghr_d;
  logic                pred_valid_q, pred_valid_d;
  logic                pred_taken_q, pred_taken_d;
  logic                mispredict_q, mispredict_d;
  logic                ready_q, ready_d;

  logic [1:0]          pht_q [DEPTH];
  logic                pht_we;
  logic [IDX_BITS-1:0] pht_waddr;
  logic [1:0]          pht_wdata;

  logic                lk_acc, rs_acc, rs_mis, lk_bit;
  logic [IDX_BITS-1:0] lk_idx, rs_idx;
  logic [1:0]          rs_cnt;

  // Nothing is accepted until the init sweep has finished.
  assign lk_acc = (state_q == S_RUN) && bus.lk_valid;
  assign rs_acc = (state_q == S_RUN) && bus.rs_valid;
  assign rs_mis = rs_acc && (bus.rs_pred != bus.rs_taken);

  // History is zero-extended into the index width before hashing with the PC.
  assign lk_idx = bus.lk_pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(spec_ghr_q);
  assign rs_idx = bus.rs_pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(bus.rs_ghr);
  assign lk_bit = pht_q[lk_idx][1];
  assign rs_cnt = pht_q[rs_idx];

  // Next-state logic: init sweep, then lookups and resolves with repair priority.
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    spec_ghr_d   = spec_ghr_q;
    arch_ghr_d   = arch_ghr_q;
    pred_ghr_d   = pred_ghr_q;
    pred_taken_d = pred_taken_q;
    pred_valid_d = 1'b0;
    mispredict_d = 1'b0;
    pht_we       = 1'b0;
    pht_waddr    = init_ptr_q;
    pht_wdata    = 2'b01;
    case (state_q)
      S_INIT: begin
        pht_we     = 1'b1;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (rs_acc) begin
          pht_we    = 1'b1;
          pht_waddr = rs_idx;
          if (bus.rs_taken) pht_wdata = (rs_cnt == 2'b11) ? 2'b11 : rs_cnt + 2'd1;
          else              pht_wdata = (rs_cnt == 2'b00) ? 2'b00 : rs_cnt - 2'd1;
          arch_ghr_d   = {arch_ghr_q[GHR_BITS-2:0], bus.rs_taken};
          mispredict_d = rs_mis;
        end
        // A mispredict squashes the concurrent lookup; the repair owns spec_ghr.
        if (lk_acc && !rs_mis) begin
          pred_valid_d = 1'b1;
          pred_taken_d = lk_bit;
          pred_ghr_d   = spec_ghr_q;
          spec_ghr_d   = {spec_ghr_q[GHR_BITS-2:0], lk_bit};
        end
        if (rs_mis) spec_ghr_d = {bus.rs_ghr[GHR_BITS-2:0], bus.rs_taken};
      end
      default: state_d = S_INIT;
    endcase
    ready_d = (state_d == S_RUN);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      init_ptr_q   <= '0;
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      pred_ghr_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      pred_ghr_q   <= pred_ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
      ready_q      <= ready_d;
    end
  end

  // PHT storage; contents are established by the init sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  assign bus.ready      = ready_q;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_ghr   = pred_ghr_q;
  assign bus.mispredict = mispredict_q;
  assign bus.arch_ghr   = arch_ghr_q;

  // PC bits outside the index window do not take part in the hash.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lk_pc[31:PC_LSB+IDX_BITS], bus.lk_pc[PC_LSB-1:0],
                            bus.rs_pc[31:PC_LSB+IDX_BITS], bus.rs_pc[PC_LSB-1:0]};
endmodule

// File: tb/tb_gshare_branch_predictor_ctrl.sv
// tb/tb_gshare_branch_predictor_ctrl.sv - scoreboard bench for the gshare predictor controller
module tb_gshare_branch_predictor_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gshare_branch_predictor_ctrl_if #(.GHR_BITS(4)) bus ();

  gshare_branch_predictor_ctrl #(.GHR_BITS(4), .IDX_BITS(4), .PC_LSB(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {int rdy; int arch; int pv; int mis; int rst;} cyc_t;
  typedef struct {int taken; int ghr;} pred_t;

  cyc_t  exp_cyc_q[$];
  pred_t exp_pred_q[$];

  int checks = 0;
  int errors = 0;

  int pht_m[16];
  int spec_m = 0;
  int arch_m = 0;
  int init_left = 16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict what the DUT shows after the next rising edge.
  task automatic step(input bit r, input bit lk, input logic [31:0] pc, input bit rs,
                      input logic [31:0] rpc, input int rg, input bit rp, input bit rt);
    cyc_t c;
    pred_t p;
    int li, ri, tk;
    bit mis;
    @(negedge clk);
    reset        = r;
    bus.lk_valid = lk;
    bus.lk_pc    = pc;
    bus.rs_valid = rs;
    bus.rs_pc    = rpc;
    bus.rs_ghr   = 4'(rg);
    bus.rs_pred  = rp;
    bus.rs_taken = rt;
    c = '{rdy: 0, arch: 0, pv: 0, mis: 0, rst: 0};
    if (r) begin
      init_left = 16;
      spec_m    = 0;
      arch_m    = 0;
      c.rst     = 1;
    end else if (init_left > 0) begin
      pht_m[16 - init_left] = 1;
      init_left--;
    end else begin
      li  = ((pc / 4) % 16) ^ spec_m;
      ri  = ((rpc / 4) % 16) ^ rg;
      tk  = (pht_m[li] >= 2) ? 1 : 0;
      mis = rs && (rp != rt);
      if (lk && !mis) begin
        p.taken = tk;
        p.ghr   = spec_m;
        exp_pred_q.push_back(p);
        spec_m  = (spec_m * 2 + tk) % 16;
        c.pv    = 1;
      end
      if (rs) begin
        if (rt) pht_m[ri] = (pht_m[ri] < 3) ? pht_m[ri] + 1 : 3;
        else    pht_m[ri] = (pht_m[ri] > 0) ? pht_m[ri] - 1 : 0;
        arch_m = (arch_m * 2 + (rt ? 1 : 0)) % 16;
      end
      if (mis) begin
        spec_m = (rg * 2 + (rt ? 1 : 0)) % 16;
        c.mis  = 1;
      end
    end
    c.rdy  = (!r && init_left == 0) ? 1 : 0;
    c.arch = arch_m;
    exp_cyc_q.push_back(c);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] rpc, input int rg, input bit rp, input bit rt);
    step(0, 0, 0, 1, rpc, rg, rp, rt);
  endtask

  // Lookup whose hashed index lands on idx given the model's current history.
  task automatic lookup_idx(input int idx);
    lookup(32'((idx ^ spec_m) * 4));
  endtask

  // Monitor: one expectation per cycle, prediction contents popped on pred_valid.
  always begin : monitor
    cyc_t  c;
    pred_t p;
    @(posedge clk);
    #1;
    if (exp_cyc_q.size() > 0) begin
      c = exp_cyc_q.pop_front();
      check("ready", 32'(bus.ready), 32'(c.rdy));
      check("arch_ghr", 32'(bus.arch_ghr), 32'(c.arch));
      check("pred_valid", 32'(bus.pred_valid), 32'(c.pv));
      check("mispredict", 32'(bus.mispredict), 32'(c.mis));
      if (c.rst != 0) begin
        check("reset_pred_taken", 32'(bus.pred_taken), 32'd0);
        check("reset_pred_ghr", 32'(bus.pred_ghr), 32'd0);
      end
      if (bus.pred_valid === 1'b1) begin
        if (exp_pred_q.size() == 0) begin
          check("pred_unexpected", 32'd1, 32'd0);
        end else begin
          p = exp_pred_q.pop_front();
          check("pred_taken", 32'(bus.pred_taken), 32'(p.taken));
          check("pred_ghr", 32'(bus.pred_ghr), 32'(p.ghr));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.lk_valid = 1'b0;
    bus.lk_pc    = '0;
    bus.rs_valid = 1'b0;
    bus.rs_pc    = '0;
    bus.rs_ghr   = '0;
    bus.rs_pred  = 1'b0;
    bus.rs_taken = 1'b0;

    // Reset and full init sweep, then touch every PHT entry.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (16) idle();
    for (int i = 0; i < 16; i++) lookup_idx(i);

    // Train index 4 to strongly taken.
    lookup(32'h10);
    resolve(32'h10, 0, 1, 1);
    resolve(32'h10, 0, 1, 1);
    lookup(32'h10);

    // Mispredict repair of speculative history.
    resolve(32'h40, 5, 0, 1);
    lookup(32'h0);

    // Lookup concurrent with a mispredicting resolve is dropped.
    step(0, 1, 32'h24, 1, 32'h8, 3, 1, 0);
    lookup(32'h0);

    // Correct resolve on the same index as a concurrent lookup: read-before-write.
    step(0, 1, 32'(((7 ^ spec_m) * 4)), 1, 32'h1c, 0, 0, 0);
    lookup_idx(7);

    // Saturation on index 11 in both directions, observed after each resolve.
    for (int i = 0; i < 5; i++) begin
      resolve(32'h20, 3, 1, 1);
      lookup_idx(11);
    end
    resolve(32'h20, 3, 0, 0);
    lookup_idx(11);
    for (int i = 0; i < 5; i++) begin
      resolve(32'h20, 3, 0, 0);
      lookup_idx(11);
    end
    resolve(32'h20, 3, 1, 1);
    lookup_idx(11);

    // Reset in mid-sweep restarts the whole sweep.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (17) idle();

    // Randomized traffic, including requests while not ready after the last reset.
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
           $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1, 1, 32'h4, 1, 32'h4, 1, 0, 1);
    for (int i = 0; i < 30; i++) begin
      step(0, 1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
           32'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    idle();
    idle();
    @(posedge clk);
    #2;
    check("cyc_queue_drained", 32'(exp_cyc_q.size()), 32'd0);
    check("pred_queue_drained", 32'(exp_pred_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
